// File: rtl/scariv_pkg.sv
// Shared frontend types for the bimodal predictor: 2-bit counter type, reset value
// and the saturating update rule.
package scariv_pkg;

  typedef logic [1:0] bim_cnt_t;

  localparam bim_cnt_t BIM_INIT = 2'b01;

  function automatic bim_cnt_t bim_next(bim_cnt_t c, logic taken);
    if (taken) begin
      return (c == 2'b11) ? c : c + 2'd1;
    end else begin
      return (c == 2'b00) ? c : c - 2'd1;
    end
  endfunction

endpackage

// File: rtl/scariv_bim_upd_ctrl.sv
// Bimodal counter-table update controller: initialises the table after reset, then turns
// each resolved conditional branch into a 2-cycle read-modify-write with same-index forwarding.
module scariv_bim_upd_ctrl
  import scariv_pkg::*;
#(
  parameter  int BIM_ENTRIES = 1024,
  parameter  int VADDR_W     = 39,
  parameter  int IDX_LSB     = 1,
  localparam int INDEX_W     = $clog2(BIM_ENTRIES)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_upd_valid,
  input  logic               i_upd_is_cond,
  input  logic               i_upd_dead,
  input  logic               i_upd_taken,
  input  logic [VADDR_W-1:0] i_upd_pc_vaddr,
  output logic               o_tbl_rd_en,
  output logic [INDEX_W-1:0] o_tbl_rd_idx,
  input  bim_cnt_t           i_tbl_rd_data,
  output logic               o_tbl_wr_en,
  output logic [INDEX_W-1:0] o_tbl_wr_idx,
  output bim_cnt_t           o_tbl_wr_data,
  output logic               o_init_busy,
  output logic               o_upd_drop
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state;
  logic [INDEX_W-1:0] init_idx;

  logic               acc_p0;
  logic [INDEX_W-1:0] idx_p0;

  logic               vld_p1;
  logic [INDEX_W-1:0] idx_p1;
  logic               taken_p1;
  logic               fwd_hit_p1;
  bim_cnt_t           old_cnt_p1;
  bim_cnt_t           new_cnt_p1;
  logic               run_wr_p1;

  logic               r_last_wr_valid;
  logic [INDEX_W-1:0] r_last_wr_idx;
  bim_cnt_t           r_last_wr_data;

  logic               unused_pc_bits;

  assign unused_pc_bits = ^i_upd_pc_vaddr;

  // Stage S0: qualify the incoming update and issue the table read
  assign acc_p0       = i_upd_valid & i_upd_is_cond & ~i_upd_dead;
  assign idx_p0       = i_upd_pc_vaddr[IDX_LSB +: INDEX_W];
  assign o_tbl_rd_en  = ~i_reset & (state == ST_RUN) & acc_p0;
  assign o_tbl_rd_idx = idx_p0;
  assign o_upd_drop   = ~i_reset & (state == ST_INIT) & acc_p0;
  assign o_init_busy  = i_reset | (state == ST_INIT);

  // Stage S1: merge forwarded value (table is read-old on collision) and write back
  assign fwd_hit_p1 = r_last_wr_valid & (r_last_wr_idx == idx_p1);
  assign old_cnt_p1 = fwd_hit_p1 ? r_last_wr_data : i_tbl_rd_data;
  assign new_cnt_p1 = bim_next(old_cnt_p1, taken_p1);
  assign run_wr_p1  = ~i_reset & (state == ST_RUN) & vld_p1;

  always_comb begin
    o_tbl_wr_en   = 1'b0;
    o_tbl_wr_idx  = init_idx;
    o_tbl_wr_data = BIM_INIT;
    if (!i_reset) begin
      if (state == ST_INIT) begin
        o_tbl_wr_en = 1'b1;
      end else if (vld_p1) begin
        o_tbl_wr_en   = 1'b1;
        o_tbl_wr_idx  = idx_p1;
        o_tbl_wr_data = new_cnt_p1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= ST_INIT;
      init_idx        <= '0;
      vld_p1          <= 1'b0;
      r_last_wr_valid <= 1'b0;
    end else begin
      if (state == ST_INIT) begin
        init_idx <= init_idx + 1'b1;
        if (init_idx == INDEX_W'(BIM_ENTRIES - 1)) begin
          state <= ST_RUN;
        end
      end
      vld_p1          <= (state == ST_RUN) & acc_p0;
      r_last_wr_valid <= run_wr_p1;
    end
  end

  always_ff @(posedge i_clk) begin
    idx_p1         <= idx_p0;
    taken_p1       <= i_upd_taken;
    r_last_wr_idx  <= idx_p1;
    r_last_wr_data <= new_cnt_p1;
  end

endmodule

// File: tb/tb_scariv_bim_upd_ctrl.sv
// Self-checking bench: external 1R1W counter table, golden per-entry counter model
// checked every cycle, plus directed sequences with literal expectations.
module tb_scariv_bim_upd_ctrl;

  localparam int N  = 1024;
  localparam int IW = 10;
  localparam int VW = 39;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_upd_valid, i_upd_is_cond, i_upd_dead, i_upd_taken;
  logic [VW-1:0] i_upd_pc_vaddr;
  logic          o_tbl_rd_en;
  logic [IW-1:0] o_tbl_rd_idx;
  logic [1:0]    tbl_rd_data;
  logic          o_tbl_wr_en;
  logic [IW-1:0] o_tbl_wr_idx;
  logic [1:0]    o_tbl_wr_data;
  logic          o_init_busy;
  logic          o_upd_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scariv_bim_upd_ctrl dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_upd_valid    (i_upd_valid),
    .i_upd_is_cond  (i_upd_is_cond),
    .i_upd_dead     (i_upd_dead),
    .i_upd_taken    (i_upd_taken),
    .i_upd_pc_vaddr (i_upd_pc_vaddr),
    .o_tbl_rd_en    (o_tbl_rd_en),
    .o_tbl_rd_idx   (o_tbl_rd_idx),
    .i_tbl_rd_data  (tbl_rd_data),
    .o_tbl_wr_en    (o_tbl_wr_en),
    .o_tbl_wr_idx   (o_tbl_wr_idx),
    .o_tbl_wr_data  (o_tbl_wr_data),
    .o_init_busy    (o_init_busy),
    .o_upd_drop     (o_upd_drop)
  );

  // External counter table: 1-cycle read, read returns old data on same-cycle write
  logic [1:0] mem [N];
  always @(posedge clk) begin
    if (o_tbl_rd_en) tbl_rd_data <= mem[o_tbl_rd_idx];
    if (o_tbl_wr_en) mem[o_tbl_wr_idx] <= o_tbl_wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Golden model: per-entry counters in commit order, plus the write expected next cycle
  int         init_cnt = 0;
  int         gold [N];
  logic       pend_v = 1'b0;
  int         pend_idx = 0;
  int         pend_data = 0;

  always @(negedge clk) begin
    logic acc;
    int   idx;
    acc = i_upd_valid & i_upd_is_cond & ~i_upd_dead;
    idx = int'(i_upd_pc_vaddr[1 +: IW]);
    if (i_reset) begin
      chk("m_rst_rd_en", o_tbl_rd_en, 0);
      chk("m_rst_wr_en", o_tbl_wr_en, 0);
      chk("m_rst_drop", o_upd_drop, 0);
      chk("m_rst_busy", o_init_busy, 1);
      init_cnt = 0;
      pend_v   = 1'b0;
    end else if (init_cnt < N) begin
      chk("m_init_busy", o_init_busy, 1);
      chk("m_init_wr_en", o_tbl_wr_en, 1);
      chk("m_init_wr_idx", o_tbl_wr_idx, init_cnt);
      chk("m_init_wr_data", o_tbl_wr_data, 1);
      chk("m_init_rd_en", o_tbl_rd_en, 0);
      chk("m_init_drop", o_upd_drop, acc);
      gold[init_cnt] = 1;
      init_cnt++;
      pend_v = 1'b0;
    end else begin
      chk("m_run_busy", o_init_busy, 0);
      chk("m_run_drop", o_upd_drop, 0);
      chk("m_run_rd_en", o_tbl_rd_en, acc);
      if (acc) chk("m_run_rd_idx", o_tbl_rd_idx, idx);
      chk("m_run_wr_en", o_tbl_wr_en, pend_v);
      if (pend_v) begin
        chk("m_run_wr_idx", o_tbl_wr_idx, pend_idx);
        chk("m_run_wr_data", o_tbl_wr_data, pend_data);
      end
      if (acc) begin
        if (i_upd_taken) gold[idx] = (gold[idx] == 3) ? 3 : gold[idx] + 1;
        else             gold[idx] = (gold[idx] == 0) ? 0 : gold[idx] - 1;
        pend_v    = 1'b1;
        pend_idx  = idx;
        pend_data = gold[idx];
      end else begin
        pend_v = 1'b0;
      end
    end
  end

  task automatic cyc(input logic rst, input logic v, input logic c, input logic d,
                     input logic t, input logic [VW-1:0] pc,
                     input logic e_rd, input logic [IW-1:0] e_ridx,
                     input logic e_wr, input logic [IW-1:0] e_widx,
                     input logic [1:0] e_wdata, input logic e_busy);
    @(posedge clk);
    #1;
    i_reset        = rst;
    i_upd_valid    = v;
    i_upd_is_cond  = c;
    i_upd_dead     = d;
    i_upd_taken    = t;
    i_upd_pc_vaddr = pc;
    @(negedge clk);
    chk("d_rd_en", o_tbl_rd_en, e_rd);
    if (e_rd) chk("d_rd_idx", o_tbl_rd_idx, e_ridx);
    chk("d_wr_en", o_tbl_wr_en, e_wr);
    if (e_wr) begin
      chk("d_wr_idx", o_tbl_wr_idx, e_widx);
      chk("d_wr_data", o_tbl_wr_data, e_wdata);
    end
    chk("d_busy", o_init_busy, e_busy);
  endtask

  initial begin
    int bad;
    i_reset        = 1'b1;
    i_upd_valid    = 1'b0;
    i_upd_is_cond  = 1'b0;
    i_upd_dead     = 1'b0;
    i_upd_taken    = 1'b0;
    i_upd_pc_vaddr = '0;
    repeat (2) @(posedge clk);

    // Initialisation sweep with a qualifying update injected at init cycle 5
    for (int c = 0; c < N + 2; c++) begin
      @(posedge clk);
      #1;
      i_reset        = 1'b0;
      i_upd_valid    = (c == 5);
      i_upd_is_cond  = (c == 5);
      i_upd_taken    = 1'b1;
      i_upd_pc_vaddr = VW'(39'h30);
      @(negedge clk);
      if (c == 0) chk("init_first_idx", o_tbl_wr_idx, 0);
      if (c == 5) begin
        chk("init_drop", o_upd_drop, 1);
        chk("init_drop_no_rd", o_tbl_rd_en, 0);
      end
      if (c == 6) chk("init_drop_pulse", o_upd_drop, 0);
      if (c == N - 1) begin
        chk("init_last_idx", o_tbl_wr_idx, N - 1);
        chk("init_last_busy", o_init_busy, 1);
      end
      if (c == N) begin
        chk("init_done_busy", o_init_busy, 0);
        chk("init_done_wr", o_tbl_wr_en, 0);
      end
    end
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== 2'b01) bad++;
    chk("init_table_all_01", bad, 0);
    chk("init_drop_entry", mem[24], 2'b01);

    // pc 0x104 -> idx 0x82, 01 taken -> 10
    cyc(0, 1, 1, 0, 1, 39'h104, 1, 10'h82, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 39'h0,   0, 0, 1, 10'h82, 2'b10, 0);

    // pc 0x200 -> idx 0x100: drive to 00, then four back-to-back taken
    cyc(0, 1, 1, 0, 0, 39'h200, 1, 10'h100, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 39'h200, 1, 10'h100, 1, 10'h100, 2'b00, 0);
    cyc(0, 1, 1, 0, 1, 39'h200, 1, 10'h100, 1, 10'h100, 2'b01, 0);
    cyc(0, 1, 1, 0, 1, 39'h200, 1, 10'h100, 1, 10'h100, 2'b10, 0);
    cyc(0, 1, 1, 0, 1, 39'h200, 1, 10'h100, 1, 10'h100, 2'b11, 0);
    cyc(0, 0, 0, 0, 0, 39'h0,   0, 0, 1, 10'h100, 2'b11, 0);
    cyc(0, 0, 0, 0, 0, 39'h0,   0, 0, 0, 0, 0, 0);
    chk("sat_hi_table", mem[256], 2'b11);

    // pc 0x40 -> idx 0x20: dead / non-cond / cond-not-taken interleave
    cyc(0, 1, 1, 0, 0, 39'h40, 1, 10'h20, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 39'h40, 0, 0, 1, 10'h20, 2'b00, 0);
    cyc(0, 1, 0, 0, 1, 39'h40, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 39'h40, 1, 10'h20, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 39'h40, 0, 0, 1, 10'h20, 2'b00, 0);
    cyc(0, 1, 0, 0, 1, 39'h40, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 39'h40, 1, 10'h20, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 39'h0,  0, 0, 1, 10'h20, 2'b00, 0);
    cyc(0, 0, 0, 0, 0, 39'h0,  0, 0, 0, 0, 0, 0);
    chk("sat_lo_table", mem[32], 2'b00);

    // Reset while S1 holds a pending write
    cyc(0, 1, 1, 0, 1, 39'h104, 1, 10'h82, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 39'h104, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 39'h0,   0, 0, 1, 10'h0, 2'b01, 1);
    cyc(0, 0, 0, 0, 0, 39'h0,   0, 0, 1, 10'h1, 2'b01, 1);
    chk("rst_abandon_entry", mem[130], 2'b10);

    repeat (N + 2) begin
      @(posedge clk);
      #1;
    end
    chk("reinit_busy", o_init_busy, 0);
    chk("reinit_entry", mem[130], 2'b01);

    cyc(0, 1, 1, 0, 1, 39'h104, 1, 10'h82, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 39'h0,   0, 0, 1, 10'h82, 2'b10, 0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
